sa_autosa_csb_initiator: RTL and testbench
==========================================

Name: sa_autosa_csb_initiator

Overview:
CSB master that turns single host register commands into 63-bit CSB request packets and collects the 34-bit responses. It sits between the host/config sequencer and any CSB responder, such as the cfgrom slave. It runs one transaction at a time, holds the request until the slave accepts it, waits for the response on reads and non-posted writes, and times out if no response arrives. Results go back to the host on a valid/ready channel.

Parameters:
TIMEOUT_CYCLES, 1024, cycles spent in WAIT before a timeout completion (must be >= 2)
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES
REQ_SRCPRIV, 1, constant value driven on the srcpriv field
REQ_LEVEL, 0, constant 2-bit value driven on the level field

Ports:
autosa_core_clk  in  1  core clock; all logic on the rising edge
autosa_core_rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  host command accepted when high together with cmd_valid
cmd_addr  in  22  word address
cmd_wdat  in  32  write data
cmd_write  in  1  1 = write, 0 = read
cmd_nposted  in  1  write expects a response (ignored for reads)
cmd_wrbe  in  4  byte enables
rsp_valid  out  1  completion valid
rsp_ready  in  1  host accepts the completion
rsp_rdat  out  32  read data (0 for writes and timeouts)
rsp_error  out  1  slave error, type mismatch, or timeout
rsp_timeout  out  1  completion was produced by a timeout
stray_resp  out  1  sticky flag: a response arrived while not in WAIT
csb_req_pd  out  63  request packet to the slave
csb_req_pvld  out  1  request valid
csb_req_prdy  in  1  slave ready
csb_resp_pd  in  34  response packet from the slave
csb_resp_valid  in  1  one-cycle response strobe; no backpressure

Behaviour:
- Reset (async, active-high) forces state IDLE and clears all outputs, csb_req_pd, the counter and stray_resp to 0. Reset in mid-transaction abandons the transaction with no completion.
- Request packet layout (registered):
  - [21:0] addr, [53:22] wdat, [54] write, [55] nposted, [56] REQ_SRCPRIV, [60:57] wrbe, [62:61] REQ_LEVEL.
  - For reads, nposted is driven 0 and wrbe is passed through.
- Response packet layout:
  - [31:0] data, [32] error, [33] type (0 = read response, 1 = write response).
- FSM: IDLE, REQ, WAIT, RESP.
  - IDLE: cmd_ready = 1. On cmd_valid, latch the packet and go to REQ; csb_req_pvld rises the next cycle.
  - REQ: csb_req_pvld = 1 with the packet held stable until csb_req_prdy. On acceptance, go to WAIT if read or non-posted write; go to IDLE if posted write (no completion is issued). csb_req_pvld drops the cycle after acceptance. cmd_ready = 0.
  - WAIT: the counter clears on entry and increments each cycle.
    - If csb_resp_valid: capture data and error, go to RESP.
    - rsp_error = resp error OR (type != expected), where expected = cmd write bit; rsp_rdat = resp data for reads, 0 for writes.
    - Else if counter == TIMEOUT_CYCLES-1: go to RESP with rsp_error = 1, rsp_timeout = 1, rsp_rdat = 0.
    - If the response and the timeout land in the same cycle, the response wins.
  - RESP: rsp_valid = 1 with fields stable until rsp_ready, then go to IDLE. Accepting the next cmd in the same cycle is not allowed; cmd_ready returns one cycle later.
- csb_resp_valid in IDLE, REQ or RESP is dropped and sets stray_resp; it stays 1 until reset.
- Throughput: the minimum command-to-command spacing for a posted write is 2 cycles when prdy = 1.
- Latency: with a slave that responds 2 cycles after pvld&prdy, rsp_valid rises 3 cycles after pvld&prdy.

Test Plan:
- Read addr 0x000010, slave returns pd {type 0, err 0, data 0xDEADBEEF} -> csb_req_pd[21:0]=0x10, [54]=0; rsp_valid with rsp_rdat=0xDEADBEEF, rsp_error=0, rsp_timeout=0.
- Posted write addr 0x3, wdat 0x12345678, wrbe 0xF, prdy=1 -> packet [53:22]=0x12345678, [55]=0; no rsp_valid; cmd_ready high again 2 cycles after cmd accept.
- Non-posted write with prdy held low 5 cycles -> pvld stays 1 and pd unchanged for 5 cycles; slave write response type 1 -> rsp_error=0, rsp_rdat=0.
- Read, no response, TIMEOUT_CYCLES=8 -> rsp_valid exactly 8 cycles after entering WAIT, rsp_error=1, rsp_timeout=1; a late response 3 cycles later sets stray_resp=1.
- Read answered with type=1 -> rsp_error=1; response with err bit set -> rsp_error=1, rsp_rdat=data.
- Reset asserted in WAIT, then a response arrives after release -> state IDLE, pvld=0, no rsp_valid, stray_resp=1; rsp_ready held low 4 cycles in RESP -> fields stable throughout.

Source files
------------

// File: rtl/sa_autosa_csb_initiator.sv
// CSB request initiator: turns one host register command at a time into a CSB request packet,
// then returns the slave's response, or a timeout, to the host on a valid/ready channel.
module sa_autosa_csb_initiator #(
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter int         CNT_W          = 16,
   parameter logic       REQ_SRCPRIV    = 1'b1,
   parameter logic [1:0] REQ_LEVEL      = 2'b00
) (
   input  logic        autosa_core_clk,
   input  logic        autosa_core_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [21:0] cmd_addr,
   input  logic [31:0] cmd_wdat,
   input  logic        cmd_write,
   input  logic        cmd_nposted,
   input  logic [3:0]  cmd_wrbe,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdat,
   output logic        rsp_error,
   output logic        rsp_timeout,
   output logic        stray_resp,
   output logic [62:0] csb_req_pd,
   output logic        csb_req_pvld,
   input  logic        csb_req_prdy,
   input  logic [33:0] csb_resp_pd,
   input  logic        csb_resp_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;

   // Reads never carry the non-posted flag; byte enables pass through unchanged.
   function automatic logic [62:0] build_pd(input logic [21:0] addr, input logic [31:0] wdat,
                                            input logic write, input logic nposted,
                                            input logic [3:0] wrbe);
      build_pd = {REQ_LEVEL, wrbe, REQ_SRCPRIV, write & nposted, write, wdat, addr};
   endfunction

   // Transaction sequencer with all host and CSB outputs registered.
   always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
      if (autosa_core_rst) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         cmd_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_rdat     <= 32'h0000_0000;
         rsp_error    <= 1'b0;
         rsp_timeout  <= 1'b0;
         stray_resp   <= 1'b0;
         csb_req_pd   <= 63'd0;
         csb_req_pvld <= 1'b0;
      end else begin
         if (csb_resp_valid && (state_r != WAIT)) begin
            stray_resp <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  csb_req_pd   <= build_pd(cmd_addr, cmd_wdat, cmd_write, cmd_nposted, cmd_wrbe);
                  csb_req_pvld <= 1'b1;
                  cmd_ready    <= 1'b0;
                  state_r      <= REQ;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            REQ: begin
               if (csb_req_prdy) begin
                  csb_req_pvld <= 1'b0;
                  cnt_r        <= {CNT_W{1'b0}};
                  // Posted writes complete silently and reopen the command port at once.
                  if (!csb_req_pd[54] || csb_req_pd[55]) begin
                     state_r <= WAIT;
                  end else begin
                     cmd_ready <= 1'b1;
                     state_r   <= IDLE;
                  end
               end else begin
                  csb_req_pvld <= 1'b1;
               end
            end
            WAIT: begin
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (csb_resp_valid) begin
                  rsp_valid   <= 1'b1;
                  rsp_rdat    <= csb_req_pd[54] ? 32'h0000_0000 : csb_resp_pd[31:0];
                  rsp_error   <= csb_resp_pd[32] | (csb_resp_pd[33] != csb_req_pd[54]);
                  rsp_timeout <= 1'b0;
                  state_r     <= RESP;
               end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_valid   <= 1'b1;
                  rsp_rdat    <= 32'h0000_0000;
                  rsp_error   <= 1'b1;
                  rsp_timeout <= 1'b1;
                  state_r     <= RESP;
               end else begin
                  state_r <= WAIT;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  rsp_valid <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sa_autosa_csb_initiator.sv
// Scenario bench for the CSB initiator; expected completions are queued when a command is
// issued and popped when the host channel presents a completion.
module tb_sa_autosa_csb_initiator;

   typedef struct packed {
      logic [31:0] rdat;
      logic        err;
      logic        to;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [21:0] cmd_addr = 22'd0;
   logic [31:0] cmd_wdat = 32'd0;
   logic        cmd_write = 1'b0, cmd_nposted = 1'b0;
   logic [3:0]  cmd_wrbe = 4'd0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [31:0] rsp_rdat;
   logic        rsp_error, rsp_timeout, stray_resp;
   logic [62:0] csb_req_pd;
   logic        csb_req_pvld, csb_req_prdy = 1'b0;
   logic [33:0] csb_resp_pd = 34'd0;
   logic        csb_resp_valid = 1'b0;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t e;

   sa_autosa_csb_initiator #(.TIMEOUT_CYCLES(8)) dut (
      .autosa_core_clk(clk), .autosa_core_rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_wdat(cmd_wdat),
      .cmd_write(cmd_write), .cmd_nposted(cmd_nposted), .cmd_wrbe(cmd_wrbe),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdat(rsp_rdat),
      .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .stray_resp(stray_resp),
      .csb_req_pd(csb_req_pd), .csb_req_pvld(csb_req_pvld), .csb_req_prdy(csb_req_prdy),
      .csb_resp_pd(csb_resp_pd), .csb_resp_valid(csb_resp_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [21:0] a, input logic [31:0] d, input logic w,
                           input logic np, input logic [3:0] be);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (cmd_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
      end
      cmd_addr = a; cmd_wdat = d; cmd_write = w; cmd_nposted = np; cmd_wrbe = be;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Issues a read and lets the slave accept it on the next edge.
   task automatic issue_read(input logic [21:0] a);
      csb_req_prdy = 1'b1;
      send_cmd(a, 32'h0, 1'b0, 1'b0, 4'hF);
      tick();
      csb_req_prdy = 1'b0;
   endtask

   task automatic slave_resp(input logic [33:0] pd);
      csb_resp_pd = pd;
      csb_resp_valid = 1'b1;
      tick();
      csb_resp_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      bit got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (rsp_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL rsp_wait: rsp_valid=%b required 1", rsp_valid);
      end
   endtask

   task automatic ack_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({cmd_ready, csb_req_pvld, rsp_valid, rsp_error, rsp_timeout, stray_resp} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000000",
                  {cmd_ready, csb_req_pvld, rsp_valid, rsp_error, rsp_timeout, stray_resp});
      end
      checks++;
      if ({csb_req_pd, rsp_rdat} !== 95'd0) begin
         errors++;
         $display("FAIL reset_data: pd=%h rdat=%h required 0", csb_req_pd, rsp_rdat);
      end
      rst = 1'b0;
      tick(); tick();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
      end
   endtask

   task automatic test_read();
      csb_req_prdy = 1'b1;
      sb.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0});
      send_cmd(22'h000010, 32'h0, 1'b0, 1'b1, 4'hF);
      checks++;
      if ({csb_req_pvld, csb_req_pd[21:0], csb_req_pd[54], csb_req_pd[55], csb_req_pd[56],
           csb_req_pd[60:57], csb_req_pd[62:61]} !== {1'b1, 22'h10, 1'b0, 1'b0, 1'b1, 4'hF, 2'b00}) begin
         errors++;
         $display("FAIL read_pkt: pvld=%b pd=%h required pvld 1 addr 10 rd np0 priv1 be F lvl0",
                  csb_req_pvld, csb_req_pd);
      end
      tick();
      csb_req_prdy = 1'b0;
      tick(); tick();
      slave_resp({1'b0, 1'b0, 32'hDEAD_BEEF});
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL read_latency: rsp_valid=%b required 1 three cycles after accept", rsp_valid);
      end
      wait_rsp();
      e = sb.pop_front();
      checks++;
      if ({rsp_rdat, rsp_error, rsp_timeout} !== e) begin
         errors++;
         $display("FAIL read_rsp: got %h/%b/%b required %h/%b/%b", rsp_rdat, rsp_error,
                  rsp_timeout, e.rdat, e.err, e.to);
      end
      ack_rsp();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_ack: rsp_valid=%b required 0", rsp_valid);
      end
   endtask

   task automatic test_posted_back_to_back();
      bit seen = 1'b0;
      csb_req_prdy = 1'b1;
      send_cmd(22'h000003, 32'h1234_5678, 1'b1, 1'b0, 4'hF);
      checks++;
      if ({csb_req_pvld, csb_req_pd[21:0], csb_req_pd[53:22], csb_req_pd[54], csb_req_pd[55]}
          !== {1'b1, 22'h3, 32'h1234_5678, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL posted_pkt: pvld=%b pd=%h required addr 3 wdat 12345678 wr np0",
                  csb_req_pvld, csb_req_pd);
      end
      tick();
      checks++;
      if ({csb_req_pvld, cmd_ready} !== 2'b01) begin
         errors++;
         $display("FAIL posted_spacing: pvld/ready=%b required 01", {csb_req_pvld, cmd_ready});
      end
      send_cmd(22'h000004, 32'h9ABC_DEF0, 1'b1, 1'b0, 4'h1);
      checks++;
      if ({csb_req_pvld, csb_req_pd[21:0], csb_req_pd[60:57]} !== {1'b1, 22'h4, 4'h1}) begin
         errors++;
         $display("FAIL back_to_back: pvld=%b pd=%h required addr 4 be 1", csb_req_pvld, csb_req_pd);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      csb_req_prdy = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL posted_no_rsp: rsp_valid seen=%b required 0", seen);
      end
   endtask

   task automatic test_nposted_stall();
      logic [62:0] exp_pd;
      exp_pd = {2'b00, 4'h3, 1'b1, 1'b1, 1'b1, 32'hA5A5_5A5A, 22'h155};
      csb_req_prdy = 1'b0;
      sb.push_back('{32'h0, 1'b0, 1'b0});
      send_cmd(22'h155, 32'hA5A5_5A5A, 1'b1, 1'b1, 4'h3);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({csb_req_pvld, csb_req_pd} !== {1'b1, exp_pd}) begin
            errors++;
            $display("FAIL npw_hold%0d: pvld=%b pd=%h required 1 %h", i, csb_req_pvld,
                     csb_req_pd, exp_pd);
         end
         tick();
      end
      csb_req_prdy = 1'b1;
      tick();
      csb_req_prdy = 1'b0;
      slave_resp({1'b1, 1'b0, 32'hFFFF_FFFF});
      wait_rsp();
      e = sb.pop_front();
      checks++;
      if ({rsp_rdat, rsp_error, rsp_timeout} !== e) begin
         errors++;
         $display("FAIL npw_rsp: got %h/%b/%b required %h/%b/%b", rsp_rdat, rsp_error,
                  rsp_timeout, e.rdat, e.err, e.to);
      end
      ack_rsp();
   endtask

   task automatic test_resp_wins();
      sb.push_back('{32'hCAFE_F00D, 1'b0, 1'b0});
      issue_read(22'h30);
      repeat (6) tick();
      slave_resp({1'b0, 1'b0, 32'hCAFE_F00D});
      wait_rsp();
      e = sb.pop_front();
      checks++;
      if ({rsp_rdat, rsp_error, rsp_timeout} !== e) begin
         errors++;
         $display("FAIL resp_wins: got %h/%b/%b required %h/%b/%b", rsp_rdat, rsp_error,
                  rsp_timeout, e.rdat, e.err, e.to);
      end
      ack_rsp();
   endtask

   task automatic test_errors();
      sb.push_back('{32'h1111_2222, 1'b1, 1'b0});
      issue_read(22'h50);
      slave_resp({1'b1, 1'b0, 32'h1111_2222});
      wait_rsp();
      e = sb.pop_front();
      checks++;
      if ({rsp_rdat, rsp_error, rsp_timeout} !== e) begin
         errors++;
         $display("FAIL type_mismatch: got %h/%b/%b required %h/%b/%b", rsp_rdat, rsp_error,
                  rsp_timeout, e.rdat, e.err, e.to);
      end
      ack_rsp();
      sb.push_back('{32'h3333_4444, 1'b1, 1'b0});
      issue_read(22'h51);
      tick();
      slave_resp({1'b0, 1'b1, 32'h3333_4444});
      wait_rsp();
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rsp_valid, rsp_rdat, rsp_error, rsp_timeout} !== {1'b1, e}) begin
            errors++;
            $display("FAIL rsp_stable%0d: got %b/%h/%b/%b required 1/%h/%b/%b", i, rsp_valid,
                     rsp_rdat, rsp_error, rsp_timeout, e.rdat, e.err, e.to);
         end
         tick();
      end
      ack_rsp();
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b00) begin
         errors++;
         $display("FAIL ready_gap: valid/ready=%b required 00", {rsp_valid, cmd_ready});
      end
      tick();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_return: cmd_ready=%b required 1", cmd_ready);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      sb.push_back('{32'h0, 1'b1, 1'b1});
      issue_read(22'h20);
      while (n < 20) begin
         tick();
         n++;
         if (rsp_valid === 1'b1) break;
      end
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d required 8", n);
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_rdat, rsp_error, rsp_timeout} !== e) begin
         errors++;
         $display("FAIL timeout_rsp: got %h/%b/%b required %h/%b/%b", rsp_rdat, rsp_error,
                  rsp_timeout, e.rdat, e.err, e.to);
      end
      checks++;
      if (stray_resp !== 1'b0) begin
         errors++;
         $display("FAIL stray_before: stray_resp=%b required 0", stray_resp);
      end
      tick(); tick();
      slave_resp({1'b0, 1'b0, 32'h5555_5555});
      checks++;
      if ({stray_resp, rsp_valid, rsp_rdat, rsp_timeout} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL late_stray: stray=%b valid=%b rdat=%h to=%b required 1 1 0 1",
                  stray_resp, rsp_valid, rsp_rdat, rsp_timeout);
      end
      ack_rsp();
   endtask

   task automatic test_reset_in_wait();
      bit seen = 1'b0;
      issue_read(22'h40);
      tick();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({csb_req_pvld, rsp_valid, stray_resp} !== 3'b000) begin
         errors++;
         $display("FAIL rst_wait: pvld/valid/stray=%b required 000",
                  {csb_req_pvld, rsp_valid, stray_resp});
      end
      tick();
      slave_resp({1'b0, 1'b0, 32'h7777_7777});
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid === 1'b1 || csb_req_pvld === 1'b1) seen = 1'b1;
         tick();
      end
      checks++;
      if ({stray_resp, seen} !== 2'b10) begin
         errors++;
         $display("FAIL rst_stray: stray/activity=%b required 10", {stray_resp, seen});
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d left required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_posted_back_to_back();
      test_nposted_stall();
      test_resp_wins();
      test_errors();
      test_timeout();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
